// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: two-source writeback arbiter for the register-file write port.
// Define RF_WR_ARB_RR_EN for round-robin arbitration; otherwise requester 0 wins.
module rf_wr_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_wa,
    output logic [DATA_WIDTH-1:0] rf_wd,
    input  logic [ADDR_WIDTH-1:0] chk_addr,
    output logic                  chk_busy,
    output logic                  idle
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        S_IDLE,
        S_WRITE
    } state_t;

    logic [1:0]                 w_valid;
    logic [1:0][ADDR_WIDTH-1:0] w_addr;
    logic [1:0][DATA_WIDTH-1:0] w_data;
    logic [1:0]                 w_full;
    logic [1:0]                 w_ne;
    logic [1:0]                 w_enq;
    logic [1:0]                 w_gnt;
    logic [1:0][ADDR_WIDTH-1:0] w_head_a;
    logic [1:0][DATA_WIDTH-1:0] w_head_d;
    logic [ADDR_WIDTH-1:0]      w_sel_a;
    logic [DATA_WIDTH-1:0]      w_sel_d;
    logic                       w_busy;

    logic [ADDR_WIDTH-1:0] r_fa [2][DEPTH];
    logic [DATA_WIDTH-1:0] r_fd [2][DEPTH];
    logic [PW-1:0]         r_wp [2];
    logic [PW-1:0]         r_rp [2];
    logic [CW-1:0]         r_cnt [2];

    state_t                r_state;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_wa;
    logic [DATA_WIDTH-1:0] r_wd;

    assign w_valid = {req1_valid, req0_valid};
    assign w_addr  = {req1_addr, req0_addr};
    assign w_data  = {req1_data, req0_data};

    // FIFO status and accept decision; x0 writes are swallowed here
    always_comb begin
        w_full   = '0;
        w_ne     = '0;
        w_enq    = '0;
        w_head_a = '0;
        w_head_d = '0;
        for (int i = 0; i < 2; i++) begin
            w_full[i]   = (r_cnt[i] == CW'(DEPTH));
            w_ne[i]     = (r_cnt[i] != '0);
            w_enq[i]    = w_valid[i] && !w_full[i] && (w_addr[i] != '0);
            w_head_a[i] = r_fa[i][r_rp[i]];
            w_head_d[i] = r_fd[i][r_rp[i]];
        end
    end

    assign req0_ready = !w_full[0];
    assign req1_ready = !w_full[1];

    // FIFO pointers, counts and storage for both requesters
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_wp[i]  <= '0;
                r_rp[i]  <= '0;
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_enq[i]) begin
                    r_fa[i][r_wp[i]] <= w_addr[i];
                    r_fd[i][r_wp[i]] <= w_data[i];
                    r_wp[i]          <= r_wp[i] + PW'(1);
                end
                if (w_gnt[i]) begin
                    r_rp[i] <= r_rp[i] + PW'(1);
                end
                if (w_enq[i] && !w_gnt[i]) begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end else if (!w_enq[i] && w_gnt[i]) begin
                    r_cnt[i] <= r_cnt[i] - CW'(1);
                end
            end
        end
    end

`ifdef RF_WR_ARB_RR_EN
    logic r_prio;

    // Round-robin grant: r_prio = 1 means requester 1 wins a tie
    always_comb begin
        w_gnt    = '0;
        w_gnt[0] = w_ne[0] && (!w_ne[1] || !r_prio);
        w_gnt[1] = w_ne[1] && (!w_ne[0] || r_prio);
    end

    // Hand priority to the other requester after each grant
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio <= 1'b0;
        end else if (w_gnt[0]) begin
            r_prio <= 1'b1;
        end else if (w_gnt[1]) begin
            r_prio <= 1'b0;
        end
    end
`else
    // Fixed priority grant: requester 0 always wins
    always_comb begin
        w_gnt    = '0;
        w_gnt[0] = w_ne[0];
        w_gnt[1] = w_ne[1] && !w_ne[0];
    end
`endif

    assign w_sel_a = w_gnt[1] ? w_head_a[1] : w_head_a[0];
    assign w_sel_d = w_gnt[1] ? w_head_d[1] : w_head_d[0];

    // Output stage: register the granted head onto the write port
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_wa    <= '0;
            r_wd    <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (|w_gnt) begin
                        r_state <= S_WRITE;
                        r_we    <= 1'b1;
                        r_wa    <= w_sel_a;
                        r_wd    <= w_sel_d;
                    end
                end
                S_WRITE: begin
                    if (|w_gnt) begin
                        r_we <= 1'b1;
                        r_wa <= w_sel_a;
                        r_wd <= w_sel_d;
                    end else begin
                        r_state <= S_IDLE;
                        r_we    <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Hazard check over occupied FIFO slots and the output stage
    always_comb begin
        logic [PW-1:0] off;
        w_busy = 1'b0;
        off    = '0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                off = PW'(j) - r_rp[i];
                if (({1'b0, off} < r_cnt[i]) && (r_fa[i][j] == chk_addr)) begin
                    w_busy = 1'b1;
                end
            end
        end
        if (r_we && (r_wa == chk_addr)) begin
            w_busy = 1'b1;
        end
        if (chk_addr == '0) begin
            w_busy = 1'b0;
        end
    end

    assign chk_busy = w_busy;
    assign rf_we    = r_we;
    assign rf_wa    = r_wa;
    assign rf_wd    = r_wd;
    assign idle     = !w_ne[0] && !w_ne[1] && !r_we;

endmodule
